// File: rtl/rom_loader_pkg.sv
// Shared definitions for the boot ROM loader: FSM encodings and stream marker.
package rom_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SYNC   = 3'd1,
    S_LEN_HI = 3'd2,
    S_LEN_LO = 3'd3,
    S_DATA   = 3'd4,
    S_CHECK  = 3'd5,
    S_DONE   = 3'd6,
    S_ERROR  = 3'd7
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/rom_loader_assembler.sv
// Word assembler: packs stream bytes MSB-first into 32-bit words and keeps
// a running XOR checksum of every byte it absorbs.
module rom_loader_assembler (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_last,
  output logic [7:0]  csum
);

  // Only the first three bytes need storing; the fourth arrives with the strobe.
  logic [23:0] shift_q, shift_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [7:0]  csum_q, csum_d;

  // Next-state for shift register, byte counter and checksum.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    csum_d  = csum_q;
    if (clear) begin
      shift_d = '0;
      cnt_d   = '0;
      csum_d  = '0;
    end else if (byte_en) begin
      shift_d = {shift_q[15:0], byte_data};
      cnt_d   = cnt_q + 2'd1;
      csum_d  = csum_q ^ byte_data;
    end
  end

  // Assembler state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shift_q <= '0;
      cnt_q   <= '0;
      csum_q  <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
    end
  end

  assign word      = {shift_q, byte_data};
  assign word_last = byte_en && (cnt_q == 2'd3);
  assign csum      = csum_q;

endmodule

// File: rtl/rom_loader.sv
// Boot ROM loader: parses a sync/length/data/checksum byte stream, writes
// 32-bit words into the ROM and holds the CPU in reset until a good load.
//
// state    | meaning
// IDLE     | after reset, waiting for start, CPU held
// SYNC     | expecting the sync marker byte
// LEN_HI   | word count, high byte
// LEN_LO   | word count, low byte; range checked here
// DATA     | assembling and writing words
// CHECK    | expecting the XOR checksum byte
// DONE     | good load, CPU released
// ERROR    | aborted load, CPU held until a good load
module rom_loader
  import rom_loader_pkg::*;
#(
  parameter int         ADDRESS_WIDTH = 10,
  parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEFAULT
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     byte_valid,
  input  logic [7:0]               byte_data,
  output logic                     byte_ready,
  output logic                     rom_write_enable,
  output logic [ADDRESS_WIDTH-1:0] rom_write_address,
  output logic [31:0]              rom_write_data,
  output logic                     cpu_hold,
  output logic                     done,
  output logic                     error
);

  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDRESS_WIDTH;

  state_t                   state_q, state_d;
  logic [15:0]              len_q, len_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [ADDRESS_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]              wr_data_q, wr_data_d;
  logic                     wr_en_q, wr_en_d;
  logic                     hold_q, hold_d;

  logic        accept;
  logic [15:0] n_words;
  logic        asm_clear, asm_byte_en, asm_word_last;
  logic [31:0] asm_word;
  logic [7:0]  asm_csum;

  rom_loader_assembler u_assembler (
    .clock     (clock),
    .reset     (reset),
    .clear     (asm_clear),
    .byte_en   (asm_byte_en),
    .byte_data (byte_data),
    .word      (asm_word),
    .word_last (asm_word_last),
    .csum      (asm_csum)
  );

  // State and datapath registers; reset aborts any load in progress.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      addr_q    <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_en_q   <= 1'b0;
      hold_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      addr_q    <= addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      hold_q    <= hold_d;
    end
  end

  // Next-state and datapath updates; len_q counts down the words still due.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    addr_d      = addr_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_en_d     = 1'b0;
    hold_d      = hold_q;
    asm_clear   = 1'b0;
    asm_byte_en = 1'b0;
    accept      = byte_valid && byte_ready;
    n_words     = {len_q[15:8], byte_data};
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d   = S_SYNC;
          addr_d    = '0;
          wr_addr_d = '0;
          asm_clear = 1'b1;
        end
      end
      S_SYNC: begin
        if (accept) state_d = (byte_data == SYNC_BYTE) ? S_LEN_HI : S_ERROR;
      end
      S_LEN_HI: begin
        if (accept) begin
          len_d[15:8] = byte_data;
          state_d     = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          len_d = n_words;
          if (n_words == 16'd0)                 state_d = S_CHECK;
          else if ({1'b0, n_words} > MAX_WORDS) state_d = S_ERROR;
          else                                  state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (accept) begin
          asm_byte_en = 1'b1;
          if (asm_word_last) begin
            wr_en_d   = 1'b1;
            wr_addr_d = addr_q;
            wr_data_d = asm_word;
            addr_d    = addr_q + 1'b1;
            len_d     = len_q - 16'd1;
            if (len_q == 16'd1) state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (accept) state_d = (byte_data == asm_csum) ? S_DONE : S_ERROR;
      end
      default: state_d = S_IDLE;
    endcase
    // The CPU is only released by a good load; IDLE keeps whatever was set.
    if (state_d == S_DONE)      hold_d = 1'b0;
    else if (state_d != S_IDLE) hold_d = 1'b1;
  end

  // Outputs decoded from the current state and registered write port.
  always_comb begin
    byte_ready        = (state_q == S_SYNC) || (state_q == S_LEN_HI) ||
                        (state_q == S_LEN_LO) || (state_q == S_DATA) ||
                        (state_q == S_CHECK);
    done              = (state_q == S_DONE);
    error             = (state_q == S_ERROR);
    cpu_hold          = hold_q;
    rom_write_enable  = wr_en_q;
    rom_write_address = wr_addr_q;
    rom_write_data    = wr_data_q;
  end

endmodule

// File: tb/tb_rom_loader.sv
// Scoreboard bench for rom_loader: scenarios push expected ROM writes, a
// negedge monitor pops and compares every write strobe the loader issues.
module tb_rom_loader;

  typedef logic [7:0] bytes_t[$];
  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clock;
  logic        reset;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        rom_write_enable;
  logic [9:0]  rom_write_address;
  logic [31:0] rom_write_data;
  logic        cpu_hold;
  logic        done;
  logic        error;

  wr_t exp_q[$];
  wr_t mon_e;
  int  checks = 0;
  int  errors = 0;

  rom_loader #(.ADDRESS_WIDTH(10), .SYNC_BYTE(8'hA5)) dut (
    .clock             (clock),
    .reset             (reset),
    .start             (start),
    .byte_valid        (byte_valid),
    .byte_data         (byte_data),
    .byte_ready        (byte_ready),
    .rom_write_enable  (rom_write_enable),
    .rom_write_address (rom_write_address),
    .rom_write_data    (rom_write_data),
    .cpu_hold          (cpu_hold),
    .done              (done),
    .error             (error)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe cycle must match the next expected write.
  always @(negedge clock) begin
    if (rom_write_enable === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write",
                 rom_write_address, rom_write_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("write_addr", {22'd0, rom_write_address}, {22'd0, mon_e.addr});
        check("write_data", rom_write_data, mon_e.data);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the byte was taken.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    if (gap) begin
      byte_valid = 1'b0;
      @(negedge clock);
    end
    byte_valid = 1'b1;
    byte_data  = b;
    n = 0;
    while (byte_ready !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL byte_timeout: got byte_ready %b expected 1", byte_ready);
    end else begin
      @(negedge clock);
    end
    byte_valid = 1'b0;
  endtask

  task automatic send_stream(input bytes_t s, input bit gap);
    foreach (s[i]) send_byte(s[i], gap);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  function automatic logic [7:0] xor_bytes(input bytes_t s, input int first, input int last);
    logic [7:0] x;
    x = 8'h00;
    for (int i = first; i <= last; i++) x = x ^ s[i];
    return x;
  endfunction

  function automatic wr_t mk_wr(input logic [9:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    return w;
  endfunction

  task automatic push_nominal_writes();
    exp_q.push_back(mk_wr(10'd0, 32'h3C010010));
    exp_q.push_back(mk_wr(10'd1, 32'h34210020));
  endtask

  bytes_t nom;
  bytes_t bad_cs;
  logic [7:0] cs_nom;

  initial begin
    reset      = 1'b0;
    start      = 1'b0;
    byte_valid = 1'b0;
    byte_data  = 8'h00;

    nom = {8'hA5, 8'h00, 8'h02, 8'h3C, 8'h01, 8'h00, 8'h10, 8'h34, 8'h21, 8'h00, 8'h20};
    // XOR of the eight data bytes works out to 0x18.
    cs_nom = xor_bytes(nom, 3, 10);
    check("cs_model", {24'd0, cs_nom}, 32'h18);
    bad_cs = nom;
    bad_cs.push_back(8'h00);
    nom.push_back(cs_nom);

    repeat (3) @(negedge clock);
    check("rst_byte_ready", {31'd0, byte_ready}, 0);
    check("rst_wr_en", {31'd0, rom_write_enable}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_error", {31'd0, error}, 0);
    check("rst_addr", {22'd0, rom_write_address}, 0);
    check("rst_data", rom_write_data, 0);
    check("rst_cpu_hold", {31'd0, cpu_hold}, 1);
    reset = 1'b1;
    @(negedge clock);

    // Bytes offered without a start are ignored.
    byte_valid = 1'b1;
    byte_data  = 8'hA5;
    repeat (5) @(negedge clock);
    check("idle_byte_ready", {31'd0, byte_ready}, 0);
    byte_valid = 1'b0;
    @(negedge clock);
    check("idle_done", {31'd0, done}, 0);
    check("idle_cpu_hold", {31'd0, cpu_hold}, 1);

    // Nominal two-word load.
    push_nominal_writes();
    pulse_start();
    send_stream(nom, 1'b0);
    @(negedge clock);
    check("nom_done", {31'd0, done}, 1);
    check("nom_error", {31'd0, error}, 0);
    check("nom_cpu_hold", {31'd0, cpu_hold}, 0);
    check("nom_byte_ready", {31'd0, byte_ready}, 0);
    check("nom_writes_left", exp_q.size(), 0);

    // Bad sync marker.
    pulse_start();
    check("sync_done_cleared", {31'd0, done}, 0);
    check("sync_cpu_hold", {31'd0, cpu_hold}, 1);
    send_byte(8'h5A, 1'b0);
    @(negedge clock);
    check("badsync_error", {31'd0, error}, 1);
    check("badsync_cpu_hold", {31'd0, cpu_hold}, 1);
    check("badsync_byte_ready", {31'd0, byte_ready}, 0);

    // Bad checksum: words stay written, load fails.
    push_nominal_writes();
    pulse_start();
    send_stream(bad_cs, 1'b0);
    @(negedge clock);
    check("badcs_error", {31'd0, error}, 1);
    check("badcs_done", {31'd0, done}, 0);
    check("badcs_cpu_hold", {31'd0, cpu_hold}, 1);
    check("badcs_writes_left", exp_q.size(), 0);

    // Backpressure gaps, plus a start pulse mid-load that must be ignored.
    push_nominal_writes();
    pulse_start();
    for (int i = 0; i < 5; i++) send_byte(nom[i], 1'b1);
    pulse_start();
    for (int i = 5; i < 12; i++) send_byte(nom[i], 1'b1);
    @(negedge clock);
    check("gap_done", {31'd0, done}, 1);
    check("gap_cpu_hold", {31'd0, cpu_hold}, 0);
    check("gap_writes_left", exp_q.size(), 0);

    // Reset after the sixth data byte: only the first word may be written.
    exp_q.push_back(mk_wr(10'd0, 32'h3C010010));
    pulse_start();
    for (int i = 0; i < 9; i++) send_byte(nom[i], 1'b0);
    reset = 1'b0;
    #1;
    check("midrst_byte_ready", {31'd0, byte_ready}, 0);
    check("midrst_wr_en", {31'd0, rom_write_enable}, 0);
    check("midrst_done", {31'd0, done}, 0);
    check("midrst_error", {31'd0, error}, 0);
    check("midrst_addr", {22'd0, rom_write_address}, 0);
    check("midrst_data", rom_write_data, 0);
    check("midrst_cpu_hold", {31'd0, cpu_hold}, 1);
    check("midrst_writes_left", exp_q.size(), 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    push_nominal_writes();
    pulse_start();
    send_stream(nom, 1'b0);
    @(negedge clock);
    check("reload_done", {31'd0, done}, 1);
    check("reload_cpu_hold", {31'd0, cpu_hold}, 0);
    check("reload_writes_left", exp_q.size(), 0);

    // N=0 with a zero checksum completes with no writes.
    pulse_start();
    send_stream('{8'hA5, 8'h00, 8'h00, 8'h00}, 1'b0);
    @(negedge clock);
    check("n0_done", {31'd0, done}, 1);
    check("n0_error", {31'd0, error}, 0);
    check("n0_cpu_hold", {31'd0, cpu_hold}, 0);

    // N=1025 exceeds a 1024-word ROM: error straight after LEN_LO.
    pulse_start();
    send_stream('{8'hA5, 8'h04, 8'h01}, 1'b0);
    check("n1025_error", {31'd0, error}, 1);
    check("n1025_byte_ready", {31'd0, byte_ready}, 0);
    check("n1025_cpu_hold", {31'd0, cpu_hold}, 1);

    repeat (3) @(negedge clock);
    check("final_writes_left", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
